instr_fetch_responder: RTL and testbench

//  Responder side of the PC->instruction-fetch interface. The PC issues a byte

---
 rtl/instr_fetch_responder_pkg.sv | 24 ++
 rtl/instr_fetch_responder_imem_array.sv | 25 ++
 rtl/instr_fetch_responder.sv | 122 ++++++++++++
 tb/tb_instr_fetch_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// NOP word, default base address and the fetch-address legality check.
package instr_fetch_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd100;
    localparam int          CNT_W             = 4;

    // Unaligned, below the base, or past the last stored word.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= 32'(depth));
    endfunction

endpackage

// File: rtl/instr_fetch_responder_imem_array.sv
// Instruction store: DEPTH x 32 words, synchronous write, asynchronous read.
// Contents are deliberately not reset; the loader fills them.
module imem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder for PC fetch requests: latches the byte address, waits LATENCY
// cycles, then presents the instruction (or an error NOP) on the rsp channel.
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 64,
    parameter int          LATENCY   = 2,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic [31:0]      rsp_addr,
    output logic             rsp_err,
    input  logic             flush,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_idx,
    input  logic [31:0]      prog_data,
    output fetch_state_e     dbg_state
);

    fetch_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic             accept;
    logic             load_rsp;
    logic [31:0]      chk_addr;
    logic [31:0]      offset;
    logic             chk_err;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;

    // Handshake: a beat transfers on a rising edge where valid && ready are
    // both high; a response, once valid, holds all rsp_* fields until taken.
    assign req_ready = !flush && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the incoming request is checked and read directly.
    assign load_rsp  = ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1))) ||
                       ((LATENCY == 1) && accept);
    assign chk_addr  = (state_q == ST_WAIT) ? addr_q : req_addr;
    assign offset    = chk_addr - BASE_ADDR;
    assign chk_err   = addr_err(chk_addr, BASE_ADDR, DEPTH);
    assign rd_idx    = IDX_W'(offset >> 2);
    assign dbg_state = state_q;

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_imem (
        .clk     (clk),
        .we      (prog_we),
        .wr_idx  (prog_idx),
        .wr_data (prog_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= NOP;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            // Read happens on the edge entering RESP, so a same-edge store
            // write is seen by the next fetch, not this one.
            if (load_rsp) begin
                rsp_valid <= 1'b1;
                rsp_instr <= chk_err ? NOP : rd_data;
                rsp_addr  <= chk_addr;
                rsp_err   <= chk_err;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            if (accept) begin
                addr_q <= req_addr;
                if (LATENCY == 1) begin
                    state_q <= ST_RESP;
                    cnt_q   <= '0;
                end else begin
                    state_q <= ST_WAIT;
                    cnt_q   <= CNT_W'(LATENCY - 1);
                end
            end else begin
                case (state_q)
                    ST_WAIT: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_RESP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_RESP: begin
                        if (rsp_ready) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: vector table of single fetches
// plus hand sequences for stall, flush, store-write collision and reset.
module tb_instr_fetch_responder;
    import instr_fetch_responder_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_instr;
    logic [31:0]  rsp_addr;
    logic         rsp_err;
    logic         flush;
    logic         prog_we;
    logic [5:0]   prog_idx;
    logic [31:0]  prog_data;
    fetch_state_e dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    instr_fetch_responder #(
        .BASE_ADDR (32'd100),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_idx  (prog_idx),
        .prog_data (prog_data),
        .dbg_state (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request with rsp_ready high, measure latency, check the response.
    // Entered and left at posedge+1.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                            input logic exp_err, input string name);
        int  waited;
        int  lat;
        bit  got;
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        for (waited = 0; waited < 20; waited++) begin
            @(negedge clk);
            if (req_ready) break;
            @(posedge clk); #1;
        end
        check32({name, " accepted"}, 32'(waited < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check32({name, " latency"}, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(LAT));
        check32({name, " instr"}, rsp_instr, exp_instr);
        check32({name, " addr"}, rsp_addr, addr);
        check32({name, " err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    // Count rsp_valid cycles over a window; anything non-zero is a stray response.
    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check32(name, 32'(seen), 32'd0);
    endtask

    // Issue three addresses back-to-back, stalling the first response for 3 cycles.
    task automatic run_back_to_back();
        logic [31:0] addrs [3];
        int          n_sent;
        int          n_got;
        int          stall_cnt;
        bit          held;
        bit          acc;
        logic [31:0] p_instr;
        logic [31:0] p_addr;
        logic        p_err;
        logic [31:0] a;
        addrs[0] = 32'd100;
        addrs[1] = 32'd104;
        addrs[2] = 32'd108;
        n_sent = 0;
        n_got = 0;
        stall_cnt = 0;
        held = 1'b0;
        p_instr = '0;
        p_addr = '0;
        p_err = 1'b0;
        req_valid = 1'b1;
        req_addr  = addrs[0];
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 60 && n_got < 3; cyc++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (rsp_valid) begin
                if (held) begin
                    check32("b2b stall instr", rsp_instr, p_instr);
                    check32("b2b stall addr", rsp_addr, p_addr);
                    check32("b2b stall err", 32'(rsp_err), 32'(p_err));
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check32("b2b unexpected rsp", rsp_addr, 32'hFFFF_FFFF);
                    end else begin
                        a = exp_q.pop_front();
                        check32("b2b order addr", rsp_addr, a);
                        check32("b2b instr", rsp_instr, mdl_mem[(a - 32'd100) >> 2]);
                    end
                    n_got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    p_instr = rsp_instr;
                    p_addr = rsp_addr;
                    p_err = rsp_err;
                    stall_cnt++;
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(req_addr);
                n_sent++;
                if (n_sent < 3) req_addr = addrs[n_sent];
                else req_valid = 1'b0;
            end
            rsp_ready = (stall_cnt >= 3);
        end
        check32("b2b responses", 32'(n_got), 32'd3);
        check32("b2b stall cycles", 32'(stall_cnt), 32'd3);
        check32("b2b queue empty", 32'(exp_q.size()), 32'd0);
        req_valid = 1'b0;
        expect_quiet("b2b no duplicate", 6);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        rsp_ready = 1'b0;
        flush = 1'b0;
        prog_we = 1'b0;
        prog_idx = '0;
        prog_data = '0;

        vecs[0]  = '{32'd100,        32'h2001_000A, 1'b0};
        vecs[1]  = '{32'd104,        32'h0C01_0101, 1'b0};
        vecs[2]  = '{32'd108,        32'h0C02_0202, 1'b0};
        vecs[3]  = '{32'd200,        32'h0C19_1919, 1'b0};
        vecs[4]  = '{32'd352,        32'h0C3F_3F3F, 1'b0};
        vecs[5]  = '{32'd102,        32'h0000_0000, 1'b1};
        vecs[6]  = '{32'd96,         32'h0000_0000, 1'b1};
        vecs[7]  = '{32'd356,        32'h0000_0000, 1'b1};
        vecs[8]  = '{32'd103,        32'h0000_0000, 1'b1};
        vecs[9]  = '{32'd0,          32'h0000_0000, 1'b1};
        vecs[10] = '{32'hFFFF_FFFC,  32'h0000_0000, 1'b1};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check32("reset rsp_instr", rsp_instr, 32'd0);
        check32("reset rsp_addr", rsp_addr, 32'd0);
        check32("reset rsp_err", 32'(rsp_err), 32'd0);
        check32("reset req_ready", 32'(req_ready), 32'd1);
        check32("reset state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Load the store
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i] = 32'h0C00_0000 + 32'(i) * 32'h0001_0101;
            if (i == 0) mdl_mem[i] = 32'h2001_000A;
            prog_we = 1'b1;
            prog_idx = 6'(i);
            prog_data = mdl_mem[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;

        // Single fetches from the vector table
        for (int v = 0; v < 11; v++) begin
            do_fetch(vecs[v].addr, vecs[v].exp_instr, vecs[v].exp_err,
                     $sformatf("vec%0d", v));
        end

        run_back_to_back();

        // Flush one cycle after accepting 104
        req_valid = 1'b1;
        req_addr = 32'd104;
        rsp_ready = 1'b1;
        @(negedge clk);
        check32("flush pre accept ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        req_addr = 32'd108;
        @(negedge clk);
        check32("flush blocks req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check32("flush state idle", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        expect_quiet("flush no response", LAT + 3);
        do_fetch(32'd200, 32'h0C19_1919, 1'b0, "post flush 200");

        // Store write on the RESP-entry edge: old word returned
        req_valid = 1'b1;
        req_addr = 32'd104;
        @(negedge clk);
        check32("wr coll accept ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        prog_we = 1'b1;
        prog_idx = 6'd1;
        prog_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        prog_we = 1'b0;
        mdl_mem[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        check32("wr coll rsp_valid", 32'(rsp_valid), 32'd1);
        check32("wr coll old word", rsp_instr, 32'h0C01_0101);
        @(posedge clk); #1;
        do_fetch(32'd104, 32'hDEAD_BEEF, 1'b0, "wr coll new word");

        // Reset in the middle of WAIT
        req_valid = 1'b1;
        req_addr = 32'd108;
        @(negedge clk);
        check32("rst mid accept ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check32("rst mid in wait", 32'(dbg_state), 32'(ST_WAIT));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check32("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        check32("rst mid req_ready", 32'(req_ready), 32'd1);
        check32("rst mid state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        expect_quiet("rst mid no stale rsp", LAT + 3);
        do_fetch(32'd100, 32'h2001_000A, 1'b0, "post reset 100");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
